rng_arbiter: RTL and testbench
==============================

Name: rng_arbiter

Overview:
Shares one `rng` instance between several requesters that each need a random byte.
- Arbitrates pending requests round-robin.
- Drives the RNG's `switch` enable for a fixed settle window, then captures `rng.out`.
- Returns the byte to the winner with a one-cycle grant/valid pulse.
- Sits between the `rng` datapath and game/display logic; it is the only driver of `rng.switch`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, RNG output width; must match `rng.out`.
- SETTLE_CYCLES, 8, clocks `rng_switch` stays high before a capture (>=1).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until its grant.
- grant  out  NUM_REQ  one-hot, one-cycle pulse to the served requester.
- data  out  WIDTH  captured random value; holds until the next capture.
- valid  out  1  one-cycle pulse, coincident with grant.
- busy  out  1  high whenever the state is not IDLE.
- rng_switch  out  1  enable to `rng.switch`.
- rng_out  in  WIDTH  from `rng.out`.

Behaviour:
- Reset (rst==0 at an edge) forces:
  - state=IDLE, grant=0, valid=0, data=0, rng_switch=0, busy=0.
  - RR pointer=NUM_REQ-1, so requester 0 has priority first.
  - settle counter=0.
  - Reset in any state aborts the draw; no grant is issued.
- States are IDLE, RUN and CAPTURE.
- IDLE:
  - rng_switch=0.
  - If any req bit is high at an edge, select the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Register the winner index, load counter=SETTLE_CYCLES-1 and go to RUN.
  - rng_switch=1 from that edge.
- RUN:
  - rng_switch=1.
  - At each edge, if req[winner]==0 the draw is abandoned: go to IDLE, no grant, pointer unchanged.
  - Otherwise, if counter!=0, decrement.
  - If counter==0: data<=rng_out, grant[winner]<=1, valid<=1, pointer<=winner, rng_switch<=0, go to CAPTURE.
- CAPTURE:
  - grant/valid are high for exactly this cycle.
  - Next edge clears them and goes to IDLE unconditionally.
- Latency: req sampled at edge E0 gives grant/valid high after edge E0+SETTLE_CYCLES. The next arbitration edge is E0+SETTLE_CYCLES+2.
- Requests arriving during RUN/CAPTURE stay pending; req changes during RUN for non-winners are ignored.
- Simultaneous requests are resolved strictly by the RR order above; no requester waits more than NUM_REQ-1 services.
- data is registered and stable between valid pulses.

Optional Feature:
- Macro: RNG_REPEAT_FILTER_EN.
- Defined:
  - In RUN at counter==0, if rng_out equals the last delivered data, stay in RUN for one extra cycle (counter stays 0) and retry.
  - After 3 consecutive rejections, capture anyway.
  - The repeat counter resets on each new grant and on reset.
  - The first draw after reset is never filtered.
- Undefined: no compare, no extra cycles; latency is exactly SETTLE_CYCLES.

Decomposition:
- Package `rng_pkg`:
  - state encoding (IDLE=2'd0, RUN=2'd1, CAPTURE=2'd2).
  - default WIDTH and SETTLE_CYCLES constants.
  - repeat-filter retry limit (3).
- One natural sub-module: `rr_select`, a combinational round-robin picker (req, pointer -> winner index, any).
- Counter and FSM stay in rng_arbiter.

Test Plan:
1. Reset: hold rst=0 for 3 edges with req=4'b1111. Expect grant=0, valid=0, data=0, rng_switch=0, busy=0 throughout.
2. Single request: req=4'b0100 at E0. Expect:
   - rng_switch high for 8 cycles;
   - grant=4'b0100 and valid=1 for one cycle after E0+8;
   - data equals rng_out sampled at edge E0+8.
3. Contention: req=4'b1111 held. Expect grants in order 0001, 0010, 0100, 1000, 0001, with a spacing of 10 cycles.
4. Abandon: req=4'b0010 asserted, then dropped at cycle 4 of RUN. Expect:
   - IDLE next cycle, no grant, data unchanged;
   - on a following req=4'b0011, requester 0 is served first (pointer unchanged).
5. Mid-draw reset: pull rst=0 at cycle 5 of RUN. Expect all outputs at reset values next cycle and no grant afterwards.
6. With RNG_REPEAT_FILTER_EN: force rng_out=8'hA5 constant over two draws. Expect the second grant delayed 3 cycles and data=8'hA5 delivered after the retry limit. Without the macro, no delay.

Source files
------------

// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rng_pkg
// Description : Shared types and constants for the rng_arbiter block.
//               State encoding, default sizing, repeat-filter retry limit.
// Revision    : 1.0 - initial release
// ============================================================================
package rng_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int c_default_width  = 8;
    localparam int c_default_settle = 8;

    // Number of consecutive repeat rejections before a capture is forced
    localparam logic [1:0] c_repeat_limit = 2'd3;

endpackage : rng_pkg
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_select
// Description : Combinational round-robin picker. Returns the first set
//               request bit searching upward from pointer+1, wrapping modulo
//               NUM_REQ.
// Ports       : req     - request vector
//               pointer - index of the most recently served requester
//               winner  - selected requester index (valid when any=1)
//               any     - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select
    import rng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    always_comb begin
        winner = '0;
        any    = 1'b0;
        // Offsets 1..NUM_REQ so the last-served requester is checked last
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(pointer) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

endmodule : rr_select
`default_nettype wire

// File: rtl/rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rng_arbiter
// Description : Shares one rng instance between NUM_REQ requesters. Picks a
//               requester round-robin, holds rng_switch high for
//               SETTLE_CYCLES clocks, captures rng_out and returns it with a
//               one-cycle grant/valid pulse.
// Ports       : clk        - system clock (rising edge)
//               rst        - synchronous active-low reset
//               req        - level requests, held until granted
//               grant      - one-hot one-cycle pulse to the served requester
//               data       - captured random value, held between captures
//               valid      - one-cycle pulse coincident with grant
//               busy       - high whenever the FSM is not IDLE
//               rng_switch - enable to rng.switch
//               rng_out    - value from rng.out
// Options     : RNG_REPEAT_FILTER_EN - reject a capture equal to the last
//               delivered value, retrying up to c_repeat_limit times.
// Revision    : 1.0 - initial release
// ============================================================================
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = c_default_width,
    parameter int SETTLE_CYCLES = c_default_settle
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [WIDTH-1:0]   data,
    output logic               valid,
    output logic               busy,
    output logic               rng_switch,
    input  logic [WIDTH-1:0]   rng_out
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   c_cnt_load  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PTR_W-1:0]   c_ptr_reset = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_one       = NUM_REQ'(1);

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_winner;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_switch;

    logic [PTR_W-1:0]   w_winner;
    logic               w_any;
    logic               w_reject;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .req     (req),
        .pointer (r_ptr),
        .winner  (w_winner),
        .any     (w_any)
    );

`ifdef RNG_REPEAT_FILTER_EN
    logic [1:0] r_rep;
    logic       r_has_data;   // a value has been delivered since reset

    assign w_reject = r_has_data && (rng_out == r_data) && (r_rep != c_repeat_limit);
`else
    assign w_reject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ptr    <= c_ptr_reset;
            r_winner <= '0;
            r_cnt    <= '0;
            r_grant  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_switch <= 1'b0;
`ifdef RNG_REPEAT_FILTER_EN
            r_rep      <= '0;
            r_has_data <= 1'b0;
`endif
        end else begin
            // grant/valid are single-cycle pulses
            r_grant <= '0;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_switch <= 1'b0;
                    if (w_any) begin
                        r_winner <= w_winner;
                        r_cnt    <= c_cnt_load;
                        r_state  <= RUN;
                        r_switch <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!req[r_winner]) begin
                        // Winner withdrew: abandon, pointer untouched
                        r_state  <= IDLE;
                        r_switch <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_reject) begin
`ifdef RNG_REPEAT_FILTER_EN
                        r_rep <= r_rep + 1'b1;
`endif
                    end else begin
                        r_data   <= rng_out;
                        r_grant  <= c_one << r_winner;
                        r_valid  <= 1'b1;
                        r_ptr    <= r_winner;
                        r_switch <= 1'b0;
                        r_state  <= CAPTURE;
`ifdef RNG_REPEAT_FILTER_EN
                        r_rep      <= '0;
                        r_has_data <= 1'b1;
`endif
                    end
                end
                CAPTURE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_switch <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign data       = r_data;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign rng_switch = r_switch;

endmodule : rng_arbiter
`default_nettype wire

// File: tb/tb_rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rng_arbiter
// Description : Self-checking bench for rng_arbiter. A driver issues draws and
//               pushes the expected grant/data/cycle into a queue; a monitor
//               pops and compares whenever valid or grant is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [W-1:0] rng_out = '0;
    logic [N-1:0] grant;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         rng_switch;

    rng_arbiter #(
        .NUM_REQ       (N),
        .WIDTH         (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .rng_switch (rng_switch),
        .rng_out    (rng_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           m_ptr  = N - 1;
    logic [W-1:0] m_last = '0;
    bit           m_has  = 1'b0;

    typedef struct {
        logic [N-1:0] g;
        logic [W-1:0] d;
        int           c;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int i = 1; i <= N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // Monitor: any grant/valid activity must match the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1 || (|grant) === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got grant=%b valid=%b expected none (cycle %0d)",
                             grant, valid, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("grant", 32'(grant), 32'(mon_e.g));
                    chk("data", 32'(data), 32'(mon_e.d));
                    chk("valid", 32'(valid), 32'd1);
                    chk("grant_cycle", cyc, mon_e.c);
                end
            end
        end
    end

    // One draw starting at the next edge. stop_at>0 ends it at RUN edge
    // stop_at, by dropping the winner's request or by reset.
    task automatic draw(input logic [N-1:0] mask, input int stop_at, input bit by_reset,
                        input bit force_cap, input logic [W-1:0] cap_val, input bit keep);
        int           w;
        int           extra;
        int           len;
        int           e0;
        logic [W-1:0] cap;
        exp_t         e;
        w     = pick(mask, m_ptr);
        cap   = force_cap ? cap_val : W'($urandom);
        extra = 0;
`ifdef RNG_REPEAT_FILTER_EN
        if (m_has && cap == m_last) extra = 3;
`endif
        len = S + extra;
        req = mask;
        rng_out = W'($urandom);
        tick();
        e0 = cyc;
        chk("busy_start", 32'(busy), 32'd1);
        chk("switch_start", 32'(rng_switch), 32'd1);
        if (stop_at == 0) begin
            e.g = N'(1) << w;
            e.d = cap;
            e.c = e0 + len;
            q.push_back(e);
        end
        for (int k = 1; k <= len; k++) begin
            if (stop_at == k) begin
                if (by_reset) rst = 1'b0;
                else req[w] = 1'b0;
            end
            // value present at edge E0+k; held at cap from the capture edge on
            rng_out = (k >= S) ? cap : W'($urandom);
            tick();
            if (stop_at == k) begin
                chk("stop_switch", 32'(rng_switch), 32'd0);
                chk("stop_busy", 32'(busy), 32'd0);
                chk("stop_grant", 32'(grant), 32'd0);
                if (by_reset) begin
                    chk("stop_data_reset", 32'(data), 32'd0);
                    m_ptr  = N - 1;
                    m_last = '0;
                    m_has  = 1'b0;
                    rst    = 1'b1;
                end else begin
                    chk("stop_data_hold", 32'(data), 32'(m_last));
                end
                req = '0;
                return;
            end
            if (k < len) chk("switch_run", 32'(rng_switch), 32'd1);
            else         chk("switch_cap", 32'(rng_switch), 32'd0);
            chk("busy_run", 32'(busy), 32'd1);
        end
        m_ptr  = w;
        m_last = cap;
        m_has  = 1'b1;
        if (!keep) req[w] = 1'b0;
        tick();
        chk("busy_after", 32'(busy), 32'd0);
        chk("data_hold", 32'(data), 32'(cap));
    endtask

    initial begin
        logic [N-1:0] mask;

        // Reset held with all requests pending
        rst = 1'b0;
        req = '1;
        repeat (3) begin
            tick();
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_data", 32'(data), 32'd0);
            chk("rst_switch", 32'(rng_switch), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b1;

        // Contention: 0001, 0010, 0100, 1000, 0001 spaced S+2 apart
        repeat (5) draw('1, 0, 1'b0, 1'b0, '0, 1'b1);

        // Single request
        draw(4'b0100, 0, 1'b0, 1'b0, '0, 1'b0);

        // Abandon at RUN cycle 4, then 0011 must serve requester 0
        draw(4'b0010, 4, 1'b0, 1'b0, '0, 1'b0);
        draw(4'b0011, 0, 1'b0, 1'b0, '0, 1'b0);

        // Reset during RUN cycle 5; nothing must be granted afterwards
        draw(4'b1000, 5, 1'b1, 1'b0, '0, 1'b0);
        repeat (4) begin
            tick();
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        // Repeated value over two draws (filtered only when enabled)
        draw(4'b0001, 0, 1'b0, 1'b1, 8'hA5, 1'b0);
        draw(4'b0001, 0, 1'b0, 1'b1, 8'hA5, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            mask = N'($urandom_range(0, (1 << N) - 1));
            if (mask == '0) begin
                req = '0;
                tick();
                chk("idle_busy", 32'(busy), 32'd0);
            end else if ($urandom_range(0, 6) == 0) begin
                draw(mask, $urandom_range(1, S), 1'b0, 1'b0, '0, 1'b0);
            end else begin
                draw(mask, 0, 1'b0, ($urandom_range(0, 9) == 0), m_last,
                     1'($urandom_range(0, 1)));
            end
        end

        req = '0;
        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rng_arbiter
`default_nettype wire
